bcd_counter_3digit: RTL and testbench

- Three-decade BCD up/down counter that produces the digit values consumed by the multiplexed seven-segment display stage.
- An internal prescaler turns the fast board clock into a count tick.
- Digits are presented as a packed 12-bit BCD word, plus an update strobe, a wrap pulse and a load-error pulse.
- Sits directly upstream of the display scan/decode block; all outputs are registered.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_counter_3digit_if.sv | 26 ++
 rtl/bcd_digit.sv | 37 +++
 rtl/bcd_counter_3digit.sv | 91 +++++++++
 tb/tb_bcd_counter_3digit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the counter and the downstream display stage.
package bcd_pkg;

    localparam int          BCD_W      = 4;
    localparam int          NUM_DIGITS = 3;
    localparam logic [3:0]  BCD_MAX    = 4'd9;

    // Packed word {hundreds, tens, units}
    typedef logic [NUM_DIGITS*BCD_W-1:0] bcd_word_t;

    // A single nibble is a legal decimal digit
    function automatic logic bcd_digit_valid(input logic [BCD_W-1:0] d);
        return (d <= BCD_MAX);
    endfunction

    // Every nibble of a packed word is a legal decimal digit
    function automatic logic bcd_word_valid(input bcd_word_t w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!bcd_digit_valid(w[i*BCD_W +: BCD_W])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_counter_3digit_if.sv
// Control and result bundle between the counter and its user.
interface bcd_counter_3digit_if;
    import bcd_pkg::*;

    logic      run;
    logic      up_down;
    logic      clear;
    logic      load;
    bcd_word_t load_value;
    bcd_word_t bcd_out;
    logic      update;
    logic      wrap;
    logic      load_err;

    // Controller side: drives commands, observes the count
    modport master (
        output run, up_down, clear, load, load_value,
        input  bcd_out, update, wrap, load_err
    );

    // Counter side
    modport slave (
        input  run, up_down, clear, load, load_value,
        output bcd_out, update, wrap, load_err
    );
endinterface

// File: rtl/bcd_digit.sv
// One decade cell: combinational next digit with carry/borrow ripple.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_in,
    input  logic             enable,
    input  logic             up_down,
    input  logic             carry_in,
    output logic [BCD_W-1:0] digit_out,
    output logic             carry_out
);

    // Step the digit only when a tick reaches this decade
    always_comb begin
        digit_out = digit_in;
        carry_out = 1'b0;
        if (enable && carry_in) begin
            if (up_down) begin
                if (digit_in >= BCD_MAX) begin
                    digit_out = '0;
                    carry_out = 1'b1;
                end else begin
                    digit_out = digit_in + BCD_W'(1);
                end
            end else begin
                // Any out-of-range code also lands on 9, keeping the word legal
                if (digit_in == '0 || digit_in > BCD_MAX) begin
                    digit_out = BCD_MAX;
                    carry_out = (digit_in == '0);
                end else begin
                    digit_out = digit_in - BCD_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_3digit.sv
// Three-decade BCD up/down counter with prescaler, load and clear.
module bcd_counter_3digit
    import bcd_pkg::*;
#(
    parameter int TICK_DIV = 5000000,
    parameter int DIV_W    = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_counter_3digit_if.slave  bus
);

    logic [DIV_W-1:0]    presc_q, presc_d;
    bcd_word_t           count_q, count_d;
    logic                update_q, update_d;
    logic                wrap_q, wrap_d;
    logic                load_err_q, load_err_d;

    logic                tick;
    bcd_word_t           count_step;
    logic [NUM_DIGITS:0] carry;

    assign tick     = bus.run && (presc_q == DIV_W'(TICK_DIV - 1));
    assign carry[0] = 1'b1;

    // Ripple chain of decade cells, units first
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        bcd_digit u_digit (
            .digit_in  (count_q[gi*BCD_W +: BCD_W]),
            .enable    (tick),
            .up_down   (bus.up_down),
            .carry_in  (carry[gi]),
            .digit_out (count_step[gi*BCD_W +: BCD_W]),
            .carry_out (carry[gi+1])
        );
    end

    // Next state: clear beats load beats tick
    always_comb begin
        presc_d    = presc_q;
        count_d    = count_q;
        update_d   = 1'b0;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.clear) begin
            count_d  = '0;
            presc_d  = '0;
            update_d = 1'b1;
        end else if (bus.load) begin
            if (bcd_word_valid(bus.load_value)) begin
                count_d  = bus.load_value;
                presc_d  = '0;
                update_d = 1'b1;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.run) begin
            if (tick) begin
                presc_d  = '0;
                count_d  = count_step;
                update_d = 1'b1;
                wrap_d   = carry[NUM_DIGITS];
            end else begin
                presc_d = presc_q + DIV_W'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            count_q    <= '0;
            update_q   <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            count_q    <= count_d;
            update_q   <= update_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.bcd_out  = count_q;
    assign bus.update   = update_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_3digit.sv
// Scoreboard bench for bcd_counter_3digit with TICK_DIV=4.
module tb_bcd_counter_3digit;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        int          c;
        logic [11:0] bcd;
        logic        wrap;
        logic        upd;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    bcd_counter_3digit_if bus ();

    bcd_counter_3digit #(.TICK_DIV(4), .DIV_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [11:0] b, input logic w, input logic e);
        exp_t x;
        x.c = c; x.bcd = b; x.wrap = w; x.upd = !e; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: match every output pulse against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                exp_t m;
                m = exp_q.pop_front();
                tests++; fails++;
                $display("FAIL missed_pulse: got none, expected bcd %h at cycle %0d", m.bcd, m.c);
            end
            if (bus.wrap && !bus.update) begin
                tests++; fails++;
                $display("FAIL wrap_without_update: got wrap=1 update=0, expected update=1 (cycle %0d)", cyc);
            end
            if (bus.update || bus.load_err || bus.wrap) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_pulse: got bcd %h upd %b err %b, expected no pulse (cycle %0d)",
                             bus.bcd_out, bus.update, bus.load_err, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    tests++;
                    if (cyc != e.c) begin
                        fails++;
                        $display("FAIL pulse_cycle: got cycle %0d, expected %0d", cyc, e.c);
                    end
                    chk("bcd_out", bus.bcd_out, e.bcd);
                    chk("wrap", {11'd0, bus.wrap}, {11'd0, e.wrap});
                    chk("update", {11'd0, bus.update}, {11'd0, e.upd});
                    chk("load_err", {11'd0, bus.load_err}, {11'd0, e.err});
                end
            end
        end
    end

    logic [11:0] t1_exp [10] = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005,
                                 12'h006, 12'h007, 12'h008, 12'h009, 12'h010};

    initial begin
        int t;
        rst = 1'b1;
        bus.run = 0; bus.up_down = 0; bus.clear = 0; bus.load = 0; bus.load_value = '0;
        repeat (3) @(negedge clk);
        chk("reset_bcd", bus.bcd_out, 12'h000);
        chk("reset_update", {11'd0, bus.update}, 12'h000);
        chk("reset_wrap", {11'd0, bus.wrap}, 12'h000);
        chk("reset_load_err", {11'd0, bus.load_err}, 12'h000);
        rst = 1'b0;
        @(negedge clk);

        // Count up 10 ticks from reset
        t = cyc;
        bus.run = 1; bus.up_down = 1;
        for (int k = 0; k < 10; k++) push(t + 4*(k+1), t1_exp[k], 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        bus.run = 0;
        $display("[TB] up count from reset done, bcd=%h", bus.bcd_out);

        // Load 999 then wrap up
        t = cyc;
        bus.load = 1; bus.load_value = 12'h999;
        push(t + 1, 12'h999, 1'b0, 1'b0);
        @(negedge clk);
        bus.load = 0; bus.run = 1; bus.up_down = 1;
        push(t + 5, 12'h000, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        bus.run = 0;
        $display("[TB] 999 up wrap done, bcd=%h", bus.bcd_out);

        // Load 100 then count down twice
        t = cyc;
        bus.load = 1; bus.load_value = 12'h100;
        push(t + 1, 12'h100, 1'b0, 1'b0);
        @(negedge clk);
        bus.load = 0; bus.up_down = 0; bus.run = 1;
        push(t + 5, 12'h099, 1'b0, 1'b0);
        push(t + 9, 12'h098, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        bus.run = 0;
        $display("[TB] 100 down borrow done, bcd=%h", bus.bcd_out);

        // Clear, then 000 down wraps to 999; up_down wiggles between ticks
        t = cyc;
        bus.clear = 1;
        push(t + 1, 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        bus.clear = 0; bus.run = 1; bus.up_down = 0;
        push(t + 5, 12'h999, 1'b1, 1'b0);
        @(negedge clk);
        bus.up_down = 1;
        @(negedge clk);
        bus.up_down = 0;
        repeat (2) @(negedge clk);
        bus.run = 0;
        $display("[TB] 000 down wrap done, bcd=%h", bus.bcd_out);

        // Rejected load of 1A3
        t = cyc;
        bus.load = 1; bus.load_value = 12'h1A3;
        push(t + 1, 12'h999, 1'b0, 1'b1);
        @(negedge clk);
        bus.load = 0;
        @(negedge clk);
        chk("bad_load_hold", bus.bcd_out, 12'h999);
        $display("[TB] invalid load done, bcd=%h", bus.bcd_out);

        // Clear+load+tick collide at 456; prescaler restarts; then freeze mid-count
        t = cyc;
        bus.load = 1; bus.load_value = 12'h456;
        push(t + 1, 12'h456, 1'b0, 1'b0);
        @(negedge clk);
        bus.load = 0; bus.run = 1; bus.up_down = 1;
        repeat (3) @(negedge clk);
        bus.clear = 1; bus.load = 1; bus.load_value = 12'h123;
        push(t + 5, 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        bus.clear = 0; bus.load = 0;
        push(t + 9, 12'h001, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        bus.run = 0;
        repeat (10) @(negedge clk);
        chk("frozen_hold", bus.bcd_out, 12'h001);
        bus.run = 1;
        push(t + 23, 12'h002, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bus.run = 0;
        $display("[TB] priority collision and freeze done, bcd=%h", bus.bcd_out);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        chk("pre_reset_bcd", bus.bcd_out, 12'h002);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_bcd", bus.bcd_out, 12'h000);
        chk("async_reset_pulses", {9'd0, bus.update, bus.wrap, bus.load_err}, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_bcd", bus.bcd_out, 12'h000);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] async reset done, bcd=%h", bus.bcd_out);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
